// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit for the uDLX execute stage: shift-add multiply and
// restoring divide, one bit per cycle, stalling the pipeline while busy.
module muldiv_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_WIDTH   = 6,
  parameter int FUNCTION_WIDTH = 6,
  parameter logic [OPCODE_WIDTH-1:0]   R_TYPE_OPCODE = 6'h00,
  parameter logic [FUNCTION_WIDTH-1:0] MULT_FUNCTION = 6'h18,
  parameter logic [FUNCTION_WIDTH-1:0] DIV_FUNCTION  = 6'h1A
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      md_start,
  input  logic [OPCODE_WIDTH-1:0]   md_opcode,
  input  logic [FUNCTION_WIDTH-1:0] md_function,
  input  logic [DATA_WIDTH-1:0]     md_data_in_a,
  input  logic [DATA_WIDTH-1:0]     md_data_in_b,
  input  logic                      md_flush,
  output logic                      md_stall,
  output logic                      md_done,
  output logic [DATA_WIDTH-1:0]     md_data_out,
  output logic                      md_div_by_zero
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t state, state_next;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] op_a, op_b, acc;
  logic [DATA_WIDTH-1:0] acc_step, a_step, b_step;
  logic [DATA_WIDTH:0]   shifted, diff;
  logic is_mult, is_div, accept, busy, last_iter, div_zero;

  assign is_mult   = (md_opcode == R_TYPE_OPCODE) && (md_function == MULT_FUNCTION);
  assign is_div    = (md_opcode == R_TYPE_OPCODE) && (md_function == DIV_FUNCTION);
  assign accept    = (state == IDLE) && md_start && !md_flush && (is_mult || is_div);
  assign div_zero  = is_div && (md_data_in_b == '0);
  assign busy      = (state == MULT) || (state == DIV);
  assign last_iter = (count == LAST_COUNT);
  assign md_stall  = accept || busy;
  assign md_done   = (state == DONE) && !md_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) begin
        if (is_mult)       state_next = MULT;
        else if (div_zero) state_next = DONE;
        else               state_next = DIV;
      end
      MULT, DIV: begin
        if (md_flush)       state_next = IDLE;
        else if (last_iter) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Divide keeps the partial remainder in acc and shifts quotient bits into op_a
  // as dividend bits leave from the top.
  always_comb begin
    shifted  = {acc, op_a[DATA_WIDTH-1]};
    diff     = shifted - {1'b0, op_b};
    acc_step = acc;
    a_step   = op_a;
    b_step   = op_b;
    if (state == MULT) begin
      acc_step = op_b[0] ? acc + op_a : acc;
      a_step   = op_a << 1;
      b_step   = op_b >> 1;
    end else if (state == DIV) begin
      acc_step = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
      a_step   = {op_a[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count          <= '0;
      op_a           <= '0;
      op_b           <= '0;
      acc            <= '0;
      md_data_out    <= '0;
      md_div_by_zero <= 1'b0;
    end else if (accept) begin
      count          <= '0;
      op_a           <= md_data_in_a;
      op_b           <= md_data_in_b;
      acc            <= '0;
      md_div_by_zero <= div_zero;
      if (div_zero) md_data_out <= '1;
    end else if (busy && !md_flush) begin
      count <= count + CNT_W'(1);
      op_a  <= a_step;
      op_b  <= b_step;
      acc   <= acc_step;
      if (last_iter) md_data_out <= (state == MULT) ? acc_step : a_step;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, stall window, results, flush,
// reset mid-operation and ignored starts.
module tb_muldiv_sequencer;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_DIV  = 6'h1A;
  localparam logic [5:0] F_ADD  = 6'h20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        md_start = 1'b0;
  logic [5:0]  md_opcode = '0;
  logic [5:0]  md_function = '0;
  logic [31:0] md_data_in_a = '0;
  logic [31:0] md_data_in_b = '0;
  logic        md_flush = 1'b0;
  logic        md_stall, md_done, md_div_by_zero;
  logic [31:0] md_data_out;

  int checks = 0;
  int failures = 0;

  muldiv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .md_start(md_start), .md_opcode(md_opcode),
    .md_function(md_function), .md_data_in_a(md_data_in_a), .md_data_in_b(md_data_in_b),
    .md_flush(md_flush), .md_stall(md_stall), .md_done(md_done),
    .md_data_out(md_data_out), .md_div_by_zero(md_div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Cycle 0 is the cycle in which the start is presented; cycle k is the k-th
  // cycle after the accepting edge. Runs a fixed window and checks the totals.
  task automatic applyStimulus(input string tag, input logic [5:0] fn,
                               input logic [31:0] a, input logic [31:0] b,
                               input int flush_cycle, input int inject_cycle,
                               input int exp_lat, input int exp_stalls, input int exp_dones,
                               input logic [31:0] exp_data, input logic exp_dbz);
    int done_cycle = -1;
    int stalls = 0;
    int dones = 0;
    @(negedge clk);
    md_start = 1'b1; md_opcode = R_TYPE; md_function = fn;
    md_data_in_a = a; md_data_in_b = b;
    md_flush = (flush_cycle == 0);
    #1;
    if (md_stall) stalls++;
    for (int cyc = 1; cyc <= 36; cyc++) begin
      @(posedge clk); #1;
      md_start = 1'b0; md_flush = 1'b0;
      md_data_in_a = 32'hDEAD_BEEF; md_data_in_b = 32'h0000_0003;
      @(negedge clk);
      if (cyc == flush_cycle) md_flush = 1'b1;
      if (cyc == inject_cycle) begin
        md_start = 1'b1; md_function = F_MULT;
        md_data_in_a = 32'd3; md_data_in_b = 32'd3;
      end
      #1;
      if (md_stall) stalls++;
      if (md_done) begin
        dones++;
        if (done_cycle < 0) done_cycle = cyc;
      end
    end
    checkOutput({tag, " latency"}, done_cycle, exp_lat);
    checkOutput({tag, " stall cycles"}, stalls, exp_stalls);
    checkOutput({tag, " done pulses"}, dones, exp_dones);
    checkOutput({tag, " data"}, md_data_out, exp_data);
    checkOutput({tag, " div_by_zero"}, 32'(md_div_by_zero), 32'(exp_dbz));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      md_start = 1'($urandom); md_function = 6'($urandom);
      md_data_in_a = $urandom; md_data_in_b = $urandom; md_flush = 1'($urandom);
      #7;
      checkOutput("reset data", md_data_out, 32'h0);
      checkOutput("reset done", 32'(md_done), 32'h0);
      checkOutput("reset dbz", 32'(md_div_by_zero), 32'h0);
    end
    md_start = 1'b0; md_flush = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    checkOutput("post-reset stall", 32'(md_stall), 32'h0);
    checkOutput("post-reset done", 32'(md_done), 32'h0);
    checkOutput("post-reset data", md_data_out, 32'h0);

    applyStimulus("mult 7*6", F_MULT, 32'd7, 32'd6, -1, -1, 33, 33, 1, 32'd42, 1'b0);
    applyStimulus("mult ovf", F_MULT, 32'hFFFF_FFFF, 32'd2, -1, -1, 33, 33, 1, 32'hFFFF_FFFE, 1'b0);
    applyStimulus("div 100/7", F_DIV, 32'd100, 32'd7, -1, -1, 33, 33, 1, 32'd14, 1'b0);
    applyStimulus("div 5/9", F_DIV, 32'd5, 32'd9, -1, -1, 33, 33, 1, 32'd0, 1'b0);
    applyStimulus("div by 0", F_DIV, 32'd123, 32'd0, -1, -1, 1, 1, 1, 32'hFFFF_FFFF, 1'b1);
    applyStimulus("mult 3*3", F_MULT, 32'd3, 32'd3, -1, -1, 33, 33, 1, 32'd9, 1'b0);
    applyStimulus("div flush@10", F_DIV, 32'd100, 32'd7, 10, -1, -1, 11, 0, 32'd9, 1'b0);

    @(negedge clk);
    md_start = 1'b1; md_opcode = R_TYPE; md_function = F_DIV;
    md_data_in_a = 32'd100; md_data_in_b = 32'd7;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1; md_start = 1'b0;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("mid-op reset data", md_data_out, 32'h0);
    checkOutput("mid-op reset stall", 32'(md_stall), 32'h0);
    checkOutput("mid-op reset done", 32'(md_done), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    applyStimulus("add ignored", F_ADD, 32'd1, 32'd2, -1, -1, -1, 0, 0, 32'h0, 1'b0);
    applyStimulus("div busy start", F_DIV, 32'd1000, 32'd10, -1, 5, 33, 33, 1, 32'd100, 1'b0);
    applyStimulus("div flush last", F_DIV, 32'd100, 32'd7, 32, -1, -1, 33, 0, 32'd100, 1'b0);
    applyStimulus("idle flush+start", F_MULT, 32'd4, 32'd4, 0, -1, -1, 0, 0, 32'd100, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide sequencer for the uDLX execute stage. It takes R-type MULT/DIV operations off the single-cycle ALU path and computes them iteratively: shift-add multiply, restoring divide, one bit per cycle. While an operation is in flight it stalls the pipeline, and it returns the result with a one-cycle done pulse for execute-stage write-back muxing.

## Interface
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH
- OPCODE_WIDTH, 6, instruction opcode width
- FUNCTION_WIDTH, 6, instruction function width
- Opcode/function encodings (R_TYPE_OPCODE, MULT_FUNCTION, DIV_FUNCTION) come from the shared opcode definitions include.

- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- md_start  in  1  qualifies opcode/function/operands this cycle
- md_opcode  in  OPCODE_WIDTH  instruction opcode
- md_function  in  FUNCTION_WIDTH  instruction function
- md_data_in_a  in  DATA_WIDTH  operand A (multiplicand / dividend)
- md_data_in_b  in  DATA_WIDTH  operand B (multiplier / divisor)
- md_flush  in  1  abort current operation (branch/exception squash)
- md_stall  out  1  hold upstream pipeline stages
- md_done  out  1  one-cycle pulse; md_data_out valid
- md_data_out  out  DATA_WIDTH  result; held until next accepted op
- md_div_by_zero  out  1  sticky with result: last DIV had B == 0

## Operation
- States: IDLE, MULT, DIV, DONE.
- Accept rule: in IDLE, md_start=1, md_opcode==R_TYPE_OPCODE, and md_function ∈ {MULT_FUNCTION, DIV_FUNCTION}.
  - On accept, latch operands, clear the iteration counter, and clear md_div_by_zero.
  - Then go to MULT or DIV.
- A start with any other opcode/function is ignored: state stays IDLE, no stall, no done.
- A start outside IDLE is ignored; the latched operands are not disturbed.
- MULT: unsigned shift-add over DATA_WIDTH iterations.
  - Result is the low DATA_WIDTH bits of the 2·DATA_WIDTH product (overflow truncated, no flag).
- DIV: unsigned restoring division over DATA_WIDTH iterations; result is the quotient, remainder discarded.
- DIV with B == 0: skip iterations, go directly to DONE, set md_data_out to all-ones, set md_div_by_zero=1.
- DONE:
  - Register the result into md_data_out and pulse md_done for one cycle.
  - Return to IDLE next cycle.
  - A new start may be accepted in the IDLE cycle that follows.
- md_stall = (IDLE and accept condition true) or state ∈ {MULT, DIV}. It is combinational from md_start so the first cycle already stalls; it is low in DONE.
- md_flush:
  - In MULT, DIV or DONE: next state IDLE, no md_done, md_data_out and md_div_by_zero unchanged.
  - In IDLE, flush overrides the same-cycle start: no accept and no stall.
- Flush on the final iteration cycle also wins: no transition to DONE.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, counter 0, md_stall 0, md_done 0, md_data_out 0, md_div_by_zero 0.
- Accept at edge T0.
- MULT/DIV occupy cycles T0+1 … T0+DATA_WIDTH. The counter runs 0 … DATA_WIDTH-1, and its last value triggers the transition.
- DONE at cycle T0+DATA_WIDTH+1: md_done=1, md_data_out valid from this cycle.
- Latency start→done is DATA_WIDTH+1 cycles (33 at default); md_stall is high for DATA_WIDTH+1 cycles (T0 … T0+DATA_WIDTH).
- Divide-by-zero: DONE at T0+1, latency 1, md_stall high only at T0.
- Back-to-back throughput: one op per DATA_WIDTH+2 cycles.
- Reset asserted mid-operation: immediate return to reset values; no done pulse.

## Test plan
- Reset check: hold rst_n low with random inputs, release -> all outputs 0, state IDLE, no stall.
- MULT: A=7, B=6 -> md_stall high for 33 cycles, md_done at cycle 33, md_data_out=42; second MULT A=0xFFFFFFFF, B=2 -> 0xFFFFFFFE.
- DIV: A=100, B=7 -> done at cycle 33, md_data_out=14, md_div_by_zero=0; A=5, B=9 -> 0.
- Divide-by-zero: A=123, B=0 -> md_done at cycle 1, md_data_out=0xFFFFFFFF, md_div_by_zero=1; next MULT 3*3 clears the flag, result 9.
- Flush and reset mid-op:
  - DIV 100/7, md_flush at cycle 10 -> IDLE next cycle, no md_done, md_data_out keeps the previous value.
  - Repeat with rst_n pulsed low at cycle 20 -> outputs reset immediately.
- Ignored starts:
  - ADD function start -> no stall, no done.
  - MULT start issued during a busy DIV (1000/10) -> ignored; DIV completes with 100 at cycle 33.
  - Flush coincident with the final iteration -> no done.
